vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 raster counter.
- Generates horizontal and vertical pixel/line counts, sync pulses with selectable polarity, and display-area flags.
- Also provides active-area x/y coordinates, line and frame start strobes, and a frame counter.
- Sits between the pixel clock domain and all pixel-generation and graphics blocks; those blocks take their raster position exclusively from it.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- HSYNC_ACTIVE_HIGH, 1, 1 = hsync high during the pulse, 0 = low
- VSYNC_ACTIVE_HIGH, 1, 1 = vsync high during the pulse, 0 = low
- CW, 10, width of all count and coordinate ports
- FRAME_W, 8, frame counter width

Ports:
- vga_clock  input  1  pixel clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  pixel clock enable; when low, all state holds
- hcount  output  CW  pixel index in the current line, 0..H_TOTAL-1
- vcount  output  CW  line index in the current frame, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per HSYNC_ACTIVE_HIGH
- vsync  output  1  vertical sync, polarity per VSYNC_ACTIVE_HIGH
- at_display_area  output  1  high when the current (hcount, vcount) is visible
- x  output  CW  active-area column; 0 outside the display area
- y  output  CW  active-area row; 0 outside the display area
- line_start  output  1  one-cycle strobe when hcount returns to 0
- frame_start  output  1  one-cycle strobe when hcount and vcount both return to 0
- frame_count  output  FRAME_W  number of completed frames, modulo 2^FRAME_W

Behaviour:
- Derived values:
  - H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (default 800).
  - V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT (default 525).
  - Segment order per axis: sync, back porch, active, front porch, starting at count 0.
- Elaboration check: a simulation $error is raised if H_TOTAL or V_TOTAL exceeds 2^CW.
- Registered outputs: every output is a register. hsync, vsync, at_display_area, x and y are computed from the next-state counts. All outputs are therefore coherent with the hcount/vcount presented in the same cycle, with zero lag.
- Counting, on each enabled cycle:
  - hcount increments, and wraps H_TOTAL-1 -> 0.
  - vcount increments only when hcount wraps, and wraps V_TOTAL-1 -> 0 only on that same cycle. It never wraps mid-line.
- Sync pulses:
  - hsync is at its active level iff hcount < H_SYNC.
  - vsync is at its active level iff vcount < V_SYNC.
- Display area:
  - at_display_area = (H_SYNC+H_BACK <= hcount < H_SYNC+H_BACK+H_ACTIVE) AND (V_SYNC+V_BACK <= vcount < V_SYNC+V_BACK+V_ACTIVE).
  - When at_display_area is high: x = hcount-(H_SYNC+H_BACK) and y = vcount-(V_SYNC+V_BACK).
  - When at_display_area is low, x and y are 0.
- Strobes:
  - line_start is high for exactly one enabled cycle, the cycle in which hcount shows 0 after a wrap.
  - frame_start is high likewise when both counts show 0 after a wrap.
  - frame_count increments, modulo 2^FRAME_W, on the same update that raises frame_start.
- enable low:
  - hcount, vcount, sync outputs, at_display_area, x, y and frame_count hold their values.
  - line_start and frame_start are forced to 0, so a strobe never lasts more than one cycle.
- reset (synchronous, active-high):
  - Takes priority over enable and may be asserted at any point in a frame, mid-line included.
  - Values on the next edge: hcount=0, vcount=0, x=0, y=0, frame_count=0, at_display_area=0, line_start=0, frame_start=0.
  - hsync and vsync go to their active levels, because count 0 lies in the sync segment.
  - The first cycle after deassertion advances to hcount=1 with no strobes.
- Boundary conditions:
  - Last pixel of the frame (H_TOTAL-1, V_TOTAL-1) -> (0, 0): line_start, frame_start and the frame_count increment all occur together in one cycle.
  - frame_count wraps from 2^FRAME_W-1 to 0 silently.

Test Plan:
- Reset with defaults and enable=1 for 2 frames -> hcount cycles 0..799, vcount 0..524; hsync high for 96 of 800 cycles; vsync high for lines 0-1; at_display_area high exactly for hcount 144..783 and vcount 35..514; x=0,y=0 at (144,35); x=639,y=479 at (783,514).
- Frame boundary -> at transition (799,524)->(0,0), line_start=1, frame_start=1 and frame_count 0->1 in one cycle; line_start pulses 525 times per frame.
- Toggle enable 1/0 alternately -> counts advance every other cycle; strobes never exceed 1 cycle; a full frame takes 2*800*525 cycles.
- Assert reset for 1 cycle at (400,200) -> next cycle (0,0) with hsync=1, vsync=1, frame_count=0, no strobes; counting resumes from 1.
- Set params to 800x600 (H 128/88/800/40, V 4/23/600/1), CW=11, HSYNC_ACTIVE_HIGH=0 -> H_TOTAL=1056, V_TOTAL=628; hsync low for hcount 0..127; display area hcount 216..1015, vcount 27..626.
- Set FRAME_W=2 and run 5 frames -> frame_count sequence 0,1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: counts, syncs, display flags, active-area coordinates, line/frame strobes.
// Every output is registered from the next-state counts, so all outputs match hcount/vcount in the same cycle.
module vga_timing_gen #(
  parameter int H_SYNC            = 96,
  parameter int H_BACK            = 48,
  parameter int H_ACTIVE          = 640,
  parameter int H_FRONT           = 16,
  parameter int V_SYNC            = 2,
  parameter int V_BACK            = 33,
  parameter int V_ACTIVE          = 480,
  parameter int V_FRONT           = 10,
  parameter int HSYNC_ACTIVE_HIGH = 1,
  parameter int VSYNC_ACTIVE_HIGH = 1,
  parameter int CW                = 10,
  parameter int FRAME_W           = 8
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic               enable,
  output logic [CW-1:0]      hcount,
  output logic [CW-1:0]      vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               at_display_area,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_LO  = H_SYNC + H_BACK;
  localparam int H_ACT_HI  = H_SYNC + H_BACK + H_ACTIVE;
  localparam int V_ACT_LO  = V_SYNC + V_BACK;
  localparam int V_ACT_HI  = V_SYNC + V_BACK + V_ACTIVE;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic HS_ON = (HSYNC_ACTIVE_HIGH != 0);
  localparam logic VS_ON = (VSYNC_ACTIVE_HIGH != 0);

  if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_h_chk
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_v_chk
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0]      r_hcount;
  logic [CW-1:0]      r_vcount;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_disp;
  logic [CW-1:0]      r_x;
  logic [CW-1:0]      r_y;
  logic               r_line_start;
  logic               r_frame_start;
  logic [FRAME_W-1:0] r_frame_count;

  logic               w_h_wrap;
  logic               w_f_wrap;
  logic [CW-1:0]      w_hnext;
  logic [CW-1:0]      w_vnext;
  logic               w_h_act;
  logic               w_v_act;
  logic               w_disp;

  // vcount only moves on the hcount wrap, so it can never wrap mid-line
  assign w_h_wrap = (r_hcount == H_LAST);
  assign w_f_wrap = w_h_wrap && (r_vcount == V_LAST);
  assign w_hnext  = w_h_wrap ? '0 : r_hcount + 1'b1;
  assign w_vnext  = w_f_wrap ? '0 : (w_h_wrap ? r_vcount + 1'b1 : r_vcount);

  assign w_h_act  = (int'(w_hnext) >= H_ACT_LO) && (int'(w_hnext) < H_ACT_HI);
  assign w_v_act  = (int'(w_vnext) >= V_ACT_LO) && (int'(w_vnext) < V_ACT_HI);
  assign w_disp   = w_h_act && w_v_act;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= HS_ON;
      r_vsync       <= VS_ON;
      r_disp        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else if (enable) begin
      r_hcount      <= w_hnext;
      r_vcount      <= w_vnext;
      r_hsync       <= (int'(w_hnext) < H_SYNC) ? HS_ON : ~HS_ON;
      r_vsync       <= (int'(w_vnext) < V_SYNC) ? VS_ON : ~VS_ON;
      r_disp        <= w_disp;
      r_x           <= w_disp ? w_hnext - CW'(H_ACT_LO) : '0;
      r_y           <= w_disp ? w_vnext - CW'(V_ACT_LO) : '0;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_f_wrap;
      if (w_f_wrap) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end else begin
      // strobes must not stretch across stalled cycles
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hcount          = r_hcount;
  assign vcount          = r_vcount;
  assign hsync           = r_hsync;
  assign vsync           = r_vsync;
  assign at_display_area = r_disp;
  assign x               = r_x;
  assign y               = r_y;
  assign line_start      = r_line_start;
  assign frame_start     = r_frame_start;
  assign frame_count     = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (13x9, active-low hsync, 2-bit frame counter).
module tb_vga_timing_gen;

  localparam int HS_W = 3, HB = 2, HA = 6, HF = 2;
  localparam int VS_W = 2, VB = 2, VA = 4, VF = 1;
  localparam int HT = HS_W + HB + HA + HF;
  localparam int VT = VS_W + VB + VA + VF;
  localparam int FT = HT * VT;

  logic       vga_clock = 1'b0;
  logic       reset     = 1'b1;
  logic       enable    = 1'b0;
  logic [4:0] hcount, vcount, x, y;
  logic       hsync, vsync, at_display_area, line_start, frame_start;
  logic [1:0] frame_count;
  logic [26:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  bit adv     = 1'b0;

  always #5 vga_clock = ~vga_clock;

  vga_timing_gen #(
    .H_SYNC(HS_W), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS_W), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HSYNC_ACTIVE_HIGH(0), .VSYNC_ACTIVE_HIGH(1), .CW(5), .FRAME_W(2)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .enable(enable),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .at_display_area(at_display_area), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
  );

  assign obs = {hcount, vcount, hsync, vsync, at_display_area, x, y,
                line_start, frame_start, frame_count};

  // Reference: raster position is just the number of enabled pixels since reset.
  function automatic logic [26:0] model_vec();
    int h, v, f;
    logic hs, vs, d;
    logic [4:0] xx, yy;
    h  = t % HT;
    v  = (t / HT) % VT;
    f  = (t / FT) % 4;
    hs = (h < HS_W) ? 1'b0 : 1'b1;
    vs = (v < VS_W);
    d  = (h >= HS_W + HB) && (h < HS_W + HB + HA) && (v >= VS_W + VB) && (v < VS_W + VB + VA);
    xx = d ? 5'(h - (HS_W + HB)) : 5'd0;
    yy = d ? 5'(v - (VS_W + VB)) : 5'd0;
    return {5'(h), 5'(v), hs, vs, d, xx, yy, adv && (h == 0), adv && (h == 0) && (v == 0), 2'(f)};
  endfunction

  task automatic cyc(input logic r, input logic e);
    reset  = r;
    enable = e;
    @(posedge vga_clock);
    if (r) begin
      t = 0; adv = 1'b0;
    end else if (e) begin
      t++; adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    n_tests++;
    if (obs !== model_vec()) begin
      n_fail++; $display("FAIL reset_state obs=%h exp=%h", obs, model_vec());
    end
    n_tests++;
    if ({hsync, vsync} !== 2'b01) begin
      n_fail++; $display("FAIL reset_sync_levels got=%b want=01", {hsync, vsync});
    end
    n_tests++;
    if ({line_start, frame_start, at_display_area, hcount, vcount} !== 13'd0) begin
      n_fail++; $display("FAIL reset_zero got ls=%b fs=%b d=%b h=%0d v=%0d",
                         line_start, frame_start, at_display_area, hcount, vcount);
    end
    cyc(1'b0, 1'b1);
    n_tests++;
    if (hcount !== 5'd1 || line_start !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_resume got h=%0d ls=%b fs=%b want h=1 ls=0 fs=0",
                         hcount, line_start, frame_start);
    end
  endtask

  task automatic test_full_frames();
    int n_ls = 0, n_fs = 0, n_hs = 0, n_d = 0;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 2 * FT; i++) begin
      cyc(1'b0, 1'b1);
      n_tests++;
      if (obs !== model_vec()) begin
        n_fail++; $display("FAIL full_frame t=%0d obs=%h exp=%h", t, obs, model_vec());
      end
      if (hcount == 5'd5 && vcount == 5'd4) begin
        n_tests++;
        if ({at_display_area, x, y} !== {1'b1, 5'd0, 5'd0}) begin
          n_fail++; $display("FAIL first_pixel got d=%b x=%0d y=%0d want 1,0,0", at_display_area, x, y);
        end
      end
      if (hcount == 5'd10 && vcount == 5'd7) begin
        n_tests++;
        if ({at_display_area, x, y} !== {1'b1, 5'd5, 5'd3}) begin
          n_fail++; $display("FAIL last_pixel got d=%b x=%0d y=%0d want 1,5,3", at_display_area, x, y);
        end
      end
      n_ls += int'(line_start);
      n_fs += int'(frame_start);
      n_hs += int'(hsync == 1'b0);
      n_d  += int'(at_display_area);
    end
    n_tests++;
    if (n_ls != 2 * VT || n_fs != 2) begin
      n_fail++; $display("FAIL strobe_counts got ls=%0d fs=%0d want ls=%0d fs=2", n_ls, n_fs, 2 * VT);
    end
    n_tests++;
    if (n_hs != 2 * VT * HS_W || n_d != 2 * HA * VA) begin
      n_fail++; $display("FAIL area_counts got hs=%0d d=%0d want hs=%0d d=%0d",
                         n_hs, n_d, 2 * VT * HS_W, 2 * HA * VA);
    end
  endtask

  task automatic test_frame_boundary();
    cyc(1'b1, 1'b1);
    repeat (FT - 1) cyc(1'b0, 1'b1);
    n_tests++;
    if ({hcount, vcount, frame_count, line_start} !== {5'd12, 5'd8, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL pre_boundary got h=%0d v=%0d fc=%0d ls=%b want 12,8,0,0",
                         hcount, vcount, frame_count, line_start);
    end
    cyc(1'b0, 1'b1);
    n_tests++;
    if ({hcount, vcount, line_start, frame_start, frame_count} !== {5'd0, 5'd0, 1'b1, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL frame_boundary got h=%0d v=%0d ls=%b fs=%b fc=%0d want 0,0,1,1,1",
                         hcount, vcount, line_start, frame_start, frame_count);
    end
  endtask

  task automatic test_enable_toggle();
    int n_fs = 0;
    logic prev_ls = 1'b0, prev_fs = 1'b0;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 2 * FT; i++) begin
      cyc(1'b0, (i % 2) == 0);
      n_tests++;
      if (obs !== model_vec() || (prev_ls && line_start) || (prev_fs && frame_start)) begin
        n_fail++; $display("FAIL enable_toggle i=%0d obs=%h exp=%h", i, obs, model_vec());
      end
      prev_ls = line_start;
      prev_fs = frame_start;
      n_fs += int'(frame_start);
    end
    n_tests++;
    if (n_fs != 1 || hcount !== 5'd0 || vcount !== 5'd0 || frame_count !== 2'd1) begin
      n_fail++; $display("FAIL toggle_frame_len got fs=%0d h=%0d v=%0d fc=%0d want 1,0,0,1",
                         n_fs, hcount, vcount, frame_count);
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b1, 1'b1);
    repeat (4 * HT + 6) cyc(1'b0, 1'b1);
    n_tests++;
    if (hcount !== 5'd6 || vcount !== 5'd4) begin
      n_fail++; $display("FAIL mid_pos got h=%0d v=%0d want 6,4", hcount, vcount);
    end
    cyc(1'b1, 1'b1);
    n_tests++;
    if ({hcount, vcount, hsync, vsync, frame_count, line_start, frame_start, at_display_area, x, y}
        !== {5'd0, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}) begin
      n_fail++; $display("FAIL mid_reset got h=%0d v=%0d hs=%b vs=%b fc=%0d ls=%b fs=%b",
                         hcount, vcount, hsync, vsync, frame_count, line_start, frame_start);
    end
    cyc(1'b0, 1'b1);
    n_tests++;
    if (hcount !== 5'd1 || vcount !== 5'd0 || line_start !== 1'b0) begin
      n_fail++; $display("FAIL mid_resume got h=%0d v=%0d ls=%b want 1,0,0", hcount, vcount, line_start);
    end
  endtask

  task automatic test_frame_wrap();
    int k = 0;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 5 * FT + 10; i++) begin
      cyc(1'b0, 1'b1);
      if (frame_start) begin
        n_tests++;
        if (frame_count !== 2'((k + 1) % 4)) begin
          n_fail++; $display("FAIL frame_wrap k=%0d got fc=%0d want %0d", k, frame_count, (k + 1) % 4);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 5) begin
      n_fail++; $display("FAIL frame_wrap_count got %0d frames want 5", k);
    end
  endtask

  task automatic test_random();
    logic r, e;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      cyc(r, e);
      n_tests++;
      if (obs !== model_vec()) begin
        n_fail++; $display("FAIL random i=%0d r=%b e=%b obs=%h exp=%h", i, r, e, obs, model_vec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_frames();
    test_frame_boundary();
    test_enable_toggle();
    test_mid_reset();
    test_frame_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
